instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/instr_fetch_if.sv | 42 ++++
 rtl/instr_fetch_pc_next.sv | 31 +++
 rtl/instr_fetch.sv | 101 ++++++++++
 tb/tb_instr_fetch.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch definitions: FSM state encoding, instruction size and
// immediate field positions used by the branch-target logic.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;

    localparam int IMM26_MSB = 25;
    localparam int IMM26_LSB = 0;
    localparam int IMM26_W   = IMM26_MSB - IMM26_LSB + 1;

    localparam int IMM19_MSB = 23;
    localparam int IMM19_LSB = 5;
    localparam int IMM19_W   = IMM19_MSB - IMM19_LSB + 1;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch bundle: instruction-memory request/response plus the held
// instruction and its ack/branch feedback from decode.
interface instr_fetch_if;

    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ack;
    logic        BrTaken;
    logic        UncondBr;
    logic [63:0] pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata,
        output instr,
        output instr_valid,
        input  instr_ack,
        input  BrTaken,
        input  UncondBr,
        output pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata,
        input  instr,
        input  instr_valid,
        output instr_ack,
        output BrTaken,
        output UncondBr,
        input  pc
    );

endinterface

// File: rtl/instr_fetch_pc_next.sv
// Combinational next-pc: sequential step or word-scaled, sign-extended
// B (imm26) / CBZ (imm19) branch offset, 64-bit wrapping add.
module pc_next
    import cpu_pkg::*;
(
    input  logic [63:0]        pc,
    input  logic [IMM26_MSB:0] imm,
    input  logic               br_taken,
    input  logic               uncond,
    output logic [63:0]        npc
);

    logic [63:0] off26;
    logic [63:0] off19;
    logic [63:0] off;

    assign off26 = {{(64 - IMM26_W - 2){imm[IMM26_MSB]}},
                    imm[IMM26_MSB:IMM26_LSB], 2'b00};
    assign off19 = {{(64 - IMM19_W - 2){imm[IMM19_MSB]}},
                    imm[IMM19_MSB:IMM19_LSB], 2'b00};

    always_comb begin
        off = 64'(INSTR_BYTES);
        if (br_taken) begin
            off = uncond ? off26 : off19;
        end
    end

    assign npc = pc + off;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: IDLE/REQ/HOLD FSM, pc and held-instruction registers.
// Define BR_STATS_EN to add saturating taken-branch counters.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
)
(
    input  logic clk,
    input  logic reset,
    instr_fetch_if.master bus
`ifdef BR_STATS_EN
    ,
    output logic [31:0] br_count,
    output logic [31:0] ubr_count
`endif
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [63:0]  pc_q;
    logic [63:0]  npc;
    logic [31:0]  instr_q;
    logic         ack_ok;
    logic         cap_ok;

    assign ack_ok = (state_q == HOLD) && bus.instr_ack;
    assign cap_ok = (state_q == REQ) && bus.imem_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ:  if (bus.imem_ready) state_d = HOLD;
            HOLD: if (bus.instr_ack) state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.imem_req    = 1'b0;
        bus.instr_valid = 1'b0;
        unique case (state_q)
            REQ:  bus.imem_req    = 1'b1;
            HOLD: bus.instr_valid = 1'b1;
            default: ;
        endcase
    end

    pc_next u_pc_next (
        .pc       (pc_q),
        .imm      (instr_q[IMM26_MSB:0]),
        .br_taken (bus.BrTaken),
        .uncond   (bus.UncondBr),
        .npc      (npc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
        end else begin
            if (ack_ok) begin
                pc_q <= npc;
            end
            if (cap_ok) begin
                instr_q <= bus.imem_rdata;
            end
        end
    end

    assign bus.pc        = pc_q;
    assign bus.imem_addr = pc_q;
    assign bus.instr     = instr_q;

`ifdef BR_STATS_EN
    // Counters stick at all-ones rather than wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_count  <= 32'h0;
            ubr_count <= 32'h0;
        end else if (ack_ok && bus.BrTaken) begin
            if (br_count != 32'hFFFF_FFFF) begin
                br_count <= br_count + 32'd1;
            end
            if (bus.UncondBr && ubr_count != 32'hFFFF_FFFF) begin
                ubr_count <= ubr_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: chained fetch/ack vectors walking pc
// through branch targets and wrap-around, plus reset corner cases.
module tb_instr_fetch;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    instr_fetch_if bus ();

`ifdef BR_STATS_EN
    logic [31:0] br_count;
    logic [31:0] ubr_count;
`endif

    instr_fetch #(
        .RESET_PC (64'h0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus)
`ifdef BR_STATS_EN
        ,
        .br_count  (br_count),
        .ubr_count (ubr_count)
`endif
    );

    typedef struct {
        logic [31:0] rdata;
        logic        br;
        logic        ub;
        logic [63:0] exp_pc;
    } vec_t;

    vec_t vecs [12];
    int checks = 0;
    int errors = 0;
    logic [63:0] prev;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (bus.imem_req !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk1("req_seen", bus.imem_req, 1'b1);
    endtask

    initial begin
        reset          = 1'b1;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.instr_ack  = 1'b0;
        bus.BrTaken    = 1'b0;
        bus.UncondBr   = 1'b0;

        // Each pc is the branch/sequential target of the row above.
        vecs[0]  = '{32'h1400_0040, 1'b1, 1'b1, 64'h100};
        vecs[1]  = '{32'h8B02_0020, 1'b0, 1'b0, 64'h104};
        vecs[2]  = '{32'h17FF_FFFF, 1'b1, 1'b1, 64'h100};
        vecs[3]  = '{32'h17FF_FFFF, 1'b1, 1'b1, 64'h0FC};
        vecs[4]  = '{32'h1400_0041, 1'b1, 1'b1, 64'h200};
        vecs[5]  = '{32'hB400_0060, 1'b1, 1'b0, 64'h20C};
        vecs[6]  = '{32'hB4FF_FFA0, 1'b1, 1'b0, 64'h200};
        vecs[7]  = '{32'hB400_0060, 1'b0, 1'b1, 64'h204};
        vecs[8]  = '{32'h17FF_FF7E, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC};
        vecs[9]  = '{32'h8B02_0020, 1'b0, 1'b0, 64'h0};
        vecs[10] = '{32'h1400_0040, 1'b0, 1'b1, 64'h4};
        vecs[11] = '{32'hB47F_FFE0, 1'b1, 1'b0, 64'h10_0000};

        #2;
        chk1("rst_req", bus.imem_req, 1'b0);
        chk1("rst_valid", bus.instr_valid, 1'b0);
        chk64("rst_pc", bus.pc, 64'h0);
        chk64("rst_instr", 64'(bus.instr), 64'h0);
        tick();
        tick();
        reset = 1'b0;
        chk1("rel_req", bus.imem_req, 1'b0);
        wait_req(2);

        prev = 64'h0;
        for (int i = 0; i < 12; i++) begin
            wait_req(4);
            chk64("addr", bus.imem_addr, prev);
            chk64("pc_req", bus.pc, prev);
            chk1("valid_in_req", bus.instr_valid, 1'b0);
            tick();
            chk1("req_held", bus.imem_req, 1'b1);
            tick();
            bus.imem_ready = 1'b1;
            bus.imem_rdata = vecs[i].rdata;
            tick();
            bus.imem_ready = 1'b0;
            bus.imem_rdata = 32'hDEAD_BEEF;
            chk1("valid", bus.instr_valid, 1'b1);
            chk1("req_in_hold", bus.imem_req, 1'b0);
            chk64("instr", 64'(bus.instr), 64'(vecs[i].rdata));

            bus.imem_ready = 1'b1;
            bus.BrTaken    = 1'b1;
            bus.UncondBr   = 1'b1;
            tick();
            bus.imem_ready = 1'b0;
            chk64("instr_stable", 64'(bus.instr), 64'(vecs[i].rdata));
            chk1("valid_stable", bus.instr_valid, 1'b1);
            chk64("pc_no_ack", bus.pc, prev);

            bus.instr_ack = 1'b1;
            bus.BrTaken   = vecs[i].br;
            bus.UncondBr  = vecs[i].ub;
            tick();
            bus.instr_ack = 1'b0;
            bus.BrTaken   = 1'b0;
            bus.UncondBr  = 1'b0;
            chk64("pc_next", bus.pc, vecs[i].exp_pc);
            chk64("addr_next", bus.imem_addr, vecs[i].exp_pc);
            chk1("req_after_ack", bus.imem_req, 1'b1);
            chk1("valid_after_ack", bus.instr_valid, 1'b0);

            bus.instr_ack = 1'b1;
            bus.BrTaken   = 1'b1;
            tick();
            bus.instr_ack = 1'b0;
            bus.BrTaken   = 1'b0;
            chk64("pc_ack_in_req", bus.pc, vecs[i].exp_pc);
            chk1("req_ack_in_req", bus.imem_req, 1'b1);
            prev = vecs[i].exp_pc;
        end

`ifdef BR_STATS_EN
        chk64("br_count", 64'(br_count), 64'd8);
        chk64("ubr_count", 64'(ubr_count), 64'd5);
`endif

        wait_req(4);
        tick();
        tick();
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h8B02_0020;
        tick();
        bus.imem_ready = 1'b0;
        chk1("hold_before_rst", bus.instr_valid, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        chk1("mid_rst_valid", bus.instr_valid, 1'b0);
        chk1("mid_rst_req", bus.imem_req, 1'b0);
        chk64("mid_rst_pc", bus.pc, 64'h0);
        chk64("mid_rst_instr", 64'(bus.instr), 64'h0);
`ifdef BR_STATS_EN
        chk64("mid_rst_br", 64'(br_count), 64'd0);
        chk64("mid_rst_ubr", 64'(ubr_count), 64'd0);
`endif
        tick();
        reset          = 1'b0;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hFFFF_FFFF;
        tick();
        bus.imem_ready = 1'b0;
        chk64("late_ready_instr", 64'(bus.instr), 64'h0);
        chk1("late_ready_valid", bus.instr_valid, 1'b0);

        wait_req(2);
        chk64("first_addr", bus.imem_addr, 64'h0);
        tick();
        tick();
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h8B02_0020;
        tick();
        bus.imem_ready = 1'b0;
        chk1("first_valid", bus.instr_valid, 1'b1);
        chk64("first_instr", 64'(bus.instr), 64'h8B02_0020);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
